mux_2x1: RTL and testbench

MUX_2X1 -- requirements
Module: mux_2x1

---
 rtl/mux_2x1.sv | 84 ++++++++
 tb/tb_mux_2x1.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1.sv
// 2:1 multiplexer with a combinational output, a registered copy, saturating
// per-select usage counters and a one-cycle pulse flagging select changes.
module mux_2x1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             S,
    input  logic             en,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             sel_chg
);

    logic [WIDTH-1:0] yq_q,      yq_d;
    logic [CNT_W-1:0] cnt0_q,    cnt0_d;
    logic [CNT_W-1:0] cnt1_q,    cnt1_d;
    logic             sel_chg_q, sel_chg_d;
    logic             s_prev_q;
    // Low for the first edge after reset so a stale s_prev cannot raise sel_chg.
    logic             armed_q;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Combinational select path, independent of clock, reset and enable.
    assign Y = S ? i1 : i0;

    // Next-state for the captured output, the counters and the change pulse.
    always_comb begin
        yq_d   = yq_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (en) begin
            yq_d = Y;
            if (S) begin
                cnt1_d = sat_inc(cnt1_q);
            end else begin
                cnt0_d = sat_inc(cnt0_q);
            end
        end else begin
            yq_d   = yq_q;
            cnt0_d = cnt0_q;
            cnt1_d = cnt1_q;
        end
        sel_chg_d = armed_q & (S != s_prev_q);
    end

    // State registers with synchronous reset taking priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            yq_q      <= {WIDTH{1'b0}};
            cnt0_q    <= {CNT_W{1'b0}};
            cnt1_q    <= {CNT_W{1'b0}};
            sel_chg_q <= 1'b0;
            s_prev_q  <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            yq_q      <= yq_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            sel_chg_q <= sel_chg_d;
            s_prev_q  <= S;
            armed_q   <= 1'b1;
        end
    end

    assign Y_q     = yq_q;
    assign cnt0    = cnt0_q;
    assign cnt1    = cnt1_q;
    assign sel_chg = sel_chg_q;

endmodule

// File: tb/tb_mux_2x1.sv
// Bench for mux_2x1: a cycle model of the block's behaviour checked every
// negative edge, plus literal expectations at key points of each scenario.
module tb_mux_2x1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, en = 1'b0, S = 1'b0;
    logic [0:0] i0 = 1'b0, i1 = 1'b0;

    logic [0:0]  Y, Y_q, Ys, Y_qs;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt0s, cnt1s;
    logic        sel_chg, sel_chgs;

    mux_2x1 #(.WIDTH(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .S(S), .en(en),
        .Y(Y), .Y_q(Y_q), .cnt0(cnt0), .cnt1(cnt1), .sel_chg(sel_chg)
    );

    mux_2x1 #(.WIDTH(1), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .S(S), .en(en),
        .Y(Ys), .Y_q(Y_qs), .cnt0(cnt0s), .cnt1(cnt1s), .sel_chg(sel_chgs)
    );

    // Behavioural model: unbounded counts, clamped only when compared.
    int m_yq = 0, m_c0 = 0, m_c1 = 0, m_sc = 0, m_prev = 0;
    bit m_first = 1'b1, m_valid = 1'b0;

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (rst) begin
            m_yq = 0; m_c0 = 0; m_c1 = 0; m_sc = 0; m_prev = 0; m_first = 1'b1;
        end else begin
            if (en) begin
                m_yq = S ? int'(i1) : int'(i0);
                if (S) m_c1 = m_c1 + 1;
                else   m_c0 = m_c0 + 1;
            end
            m_sc    = (!m_first && int'(S) != m_prev) ? 1 : 0;
            m_prev  = int'(S);
            m_first = 1'b0;
        end
    end

    function automatic int clamp(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    int n_vec = 0, n_err = 0;
    event chk_ev;
    int lit_seq = 0;
    int lit_y, lit_yq, lit_c0, lit_c1, lit_sc, lit_c1s;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Single compare process: model every negedge / on request, literals on request.
    initial begin
        int seen_seq;
        seen_seq = 0;
        forever begin
            @(negedge clk or chk_ev);
            cmp("Y", Y, S ? i1 : i0);
            cmp("Y_s", Ys, S ? i1 : i0);
            if (m_valid) begin
                cmp("Y_q", Y_q, m_yq);
                cmp("cnt0", cnt0, clamp(m_c0, 65535));
                cmp("cnt1", cnt1, clamp(m_c1, 65535));
                cmp("sel_chg", sel_chg, m_sc);
                cmp("Y_q_s", Y_qs, m_yq);
                cmp("cnt0_s", cnt0s, clamp(m_c0, 3));
                cmp("cnt1_s", cnt1s, clamp(m_c1, 3));
                cmp("sel_chg_s", sel_chgs, m_sc);
            end
            if (lit_seq != seen_seq) begin
                seen_seq = lit_seq;
                if (lit_y   >= 0) cmp("lit_Y", Y, lit_y);
                if (lit_yq  >= 0) begin cmp("lit_Y_q", Y_q, lit_yq); cmp("model_Y_q", m_yq, lit_yq); end
                if (lit_c0  >= 0) begin cmp("lit_cnt0", cnt0, lit_c0); cmp("model_cnt0", clamp(m_c0, 65535), lit_c0); end
                if (lit_c1  >= 0) begin cmp("lit_cnt1", cnt1, lit_c1); cmp("model_cnt1", clamp(m_c1, 65535), lit_c1); end
                if (lit_sc  >= 0) begin cmp("lit_sel_chg", sel_chg, lit_sc); cmp("model_sel_chg", m_sc, lit_sc); end
                if (lit_c1s >= 0) begin cmp("lit_cnt1_sat", cnt1s, lit_c1s); cmp("model_cnt1_sat", clamp(m_c1, 3), lit_c1s); end
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic s, input logic a0, input logic a1);
        @(negedge clk);
        #1;
        rst = r; en = e; S = s; i0 = a0; i1 = a1;
    endtask

    // Literal expectations (-1 = not checked); edge=1 waits for the capture edge first.
    task automatic lit(input bit edge_w, input int y, input int yq, input int c0,
                       input int c1, input int sc, input int c1s);
        if (edge_w) begin
            @(posedge clk);
            #2;
        end else begin
            #1;
        end
        lit_y = y; lit_yq = yq; lit_c0 = c0; lit_c1 = c1; lit_sc = sc; lit_c1s = c1s;
        lit_seq = lit_seq + 1;
        ->chk_ev;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] y_tab;
        logic [2:0] rv [12];
        y_tab = 8'b1101_1000;   // Y for index {i0,i1,S}
        rv = '{3'b001, 3'b110, 3'b011, 3'b100, 3'b111, 3'b010,
               3'b000, 3'b101, 3'b110, 3'b001, 3'b111, 3'b010};  // {S,i1,i0}

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        lit(1'b1, 0, 0, 0, 0, 0, 0);

        // Exhaustive combinational path, held in reset to show Y ignores rst
        for (int k = 0; k < 8; k++) begin
            logic [2:0] idx;
            idx = 3'(k);
            @(negedge clk);
            #1;
            i0 = idx[2]; i1 = idx[1]; S = idx[0];
            lit(1'b0, int'(y_tab[k]), -1, -1, -1, -1, -1);
        end

        // Select first, data 10 ns later, check 1 ns after the data change
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            S = rv[k][2];
            #10;
            i1 = rv[k][1]; i0 = rv[k][0];
            #1;
            ->chk_ev;
        end

        // Registered path and hold with en=0
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        lit(1'b1, 1, 1, 1, 0, 0, -1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        lit(1'b1, 0, 1, 1, 0, 0, -1);

        // S and data change together: new S selects new data
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        lit(1'b1, 1, 1, 2, 1, 1, 1);

        // Mid-operation reset, then counting resumes from zero
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        lit(1'b1, 1, 0, 0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        lit(1'b1, 1, 1, 1, 0, 0, 0);

        // Select-change pulse for S = 0,0,1,1,0
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  lit(1'b1, -1, -1, -1, -1, 0, -1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  lit(1'b1, -1, -1, -1, -1, 0, -1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  lit(1'b1, -1, -1, -1, -1, 1, -1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  lit(1'b1, -1, -1, -1, -1, 0, -1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  lit(1'b1, -1, -1, 3, 2, 1, 2);

        // Saturation (2-bit instance) and no sel_chg on the first edge after reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        lit(1'b1, 1, 1, 0, 1, 0, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        lit(1'b1, 1, 1, 0, 5, 0, 3);

        // Reset wins over en; Y still follows the inputs during reset
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        lit(1'b1, 1, 0, 0, 0, 0, 0);
        S = 1'b0; i0 = 1'b1;
        lit(1'b0, 1, 0, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
